// File: rtl/data_2048x2_arb.sv
// data_2048x2_arb: post-reset / on-demand fill sweep, round-robin 2:1 read arbiter
// and write passthrough in front of a 2048x2 1R1W array macro.
module data_2048x2_arb #(
   parameter logic [1:0] INIT_VALUE = 2'b00
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        clr_req,
   output logic        init_done,
   input  logic        rd0_valid,
   input  logic [10:0] rd0_addr,
   output logic        rd0_ready,
   input  logic        rd1_valid,
   input  logic [10:0] rd1_addr,
   output logic        rd1_ready,
   input  logic        wr_valid,
   input  logic [10:0] wr_addr,
   input  logic [1:0]  wr_data,
   output logic        wr_ready,
   output logic        rsp_valid,
   output logic        rsp_id,
   output logic [1:0]  rsp_data,
   output logic [10:0] mem_R0_addr,
   output logic        mem_R0_en,
   input  logic [1:0]  mem_R0_data,
   output logic [10:0] mem_W0_addr,
   output logic        mem_W0_en,
   output logic [1:0]  mem_W0_data
);
   localparam logic [0:0] S_INIT = 1'b0;
   localparam logic [0:0] S_IDLE = 1'b1;
   logic [0:0]  state_q, state_d;
   logic [10:0] cnt_q, cnt_d;
   logic        init_done_q, init_done_d;
   logic        prio_q, prio_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_id_q, rsp_id_d;
   logic        idle, open, gnt1, rd_fire;
   always_comb begin
      idle        = state_q == S_IDLE;
      open        = idle && !clr_req;
      gnt1        = rd1_valid && (!rd0_valid || prio_q);
      rd_fire     = open && (rd0_valid || rd1_valid);
      state_d     = idle ? (clr_req ? S_INIT : S_IDLE) : (&cnt_q ? S_IDLE : S_INIT);
      cnt_d       = idle ? 11'd0 : cnt_q + 11'd1;
      init_done_d = state_d == S_IDLE;
      prio_d      = rd_fire ? !gnt1 : prio_q;
      rsp_valid_d = rd_fire;
      rsp_id_d    = rd_fire ? gnt1 : rsp_id_q;
   end
   // the sweep owns the write port for the whole of INIT, including while in reset
   assign mem_W0_en   = idle ? open && wr_valid : 1'b1;
   assign mem_W0_addr = idle ? wr_addr : cnt_q;
   assign mem_W0_data = idle ? wr_data : INIT_VALUE;
   assign mem_R0_en   = rd_fire;
   assign mem_R0_addr = gnt1 ? rd1_addr : rd0_addr;
   assign rd0_ready   = open && rd0_valid && !gnt1;
   assign rd1_ready   = open && gnt1;
   assign wr_ready    = open;
   assign init_done   = init_done_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_id      = rsp_id_q;
   assign rsp_data    = mem_R0_data;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_INIT;
         cnt_q       <= 11'd0;
         init_done_q <= 1'b0;
         prio_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         init_done_q <= init_done_d;
         prio_q      <= prio_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
      end
   end
endmodule

// File: tb/tb_data_2048x2_arb.sv
// tb_data_2048x2_arb: random stimulus against an array-level reference model,
// responses checked by a scoreboard queue and an independent monitor.
module tb_data_2048x2_arb;
   logic        clock = 1'b0;
   logic        reset_n, clr_req, init_done;
   logic        rd0_valid, rd0_ready, rd1_valid, rd1_ready;
   logic [10:0] rd0_addr, rd1_addr, wr_addr;
   logic        wr_valid, wr_ready;
   logic [1:0]  wr_data;
   logic        rsp_valid, rsp_id;
   logic [1:0]  rsp_data;
   logic [10:0] mem_R0_addr, mem_W0_addr;
   logic        mem_R0_en, mem_W0_en;
   logic [1:0]  mem_R0_data, mem_W0_data;

   data_2048x2_arb dut (
      .clock(clock), .reset_n(reset_n), .clr_req(clr_req), .init_done(init_done),
      .rd0_valid(rd0_valid), .rd0_addr(rd0_addr), .rd0_ready(rd0_ready),
      .rd1_valid(rd1_valid), .rd1_addr(rd1_addr), .rd1_ready(rd1_ready),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .mem_R0_addr(mem_R0_addr), .mem_R0_en(mem_R0_en), .mem_R0_data(mem_R0_data),
      .mem_W0_addr(mem_W0_addr), .mem_W0_en(mem_W0_en), .mem_W0_data(mem_W0_data)
   );

   always #5 clock = ~clock;

   // array macro: registered read address, so a same-edge write is seen by the read
   logic [1:0]  mem [2048];
   logic [10:0] raddr_q = 11'd0;
   bit          poisoned = 1'b0;
   always @(posedge clock) begin
      if (!poisoned) begin
         for (int i = 0; i < 2048; i++) mem[i] <= 2'(i % 3 + 1);
         poisoned <= 1'b1;
      end else if (mem_W0_en) mem[mem_W0_addr] <= mem_W0_data;
      if (mem_R0_en) raddr_q <= mem_R0_addr;
   end
   assign mem_R0_data = mem[raddr_q];

   typedef struct { int cyc; logic id; logic [1:0] d; } exp_t;
   exp_t       sb [$];
   exp_t       mon_e;
   logic [1:0] ref_mem [2048];
   int         last_win;
   int         cyc = 0;
   int         n_chk = 0, n_err = 0;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endfunction

   always @(negedge clock) begin
      if (reset_n && rsp_valid) begin
         if (sb.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
         else begin
            mon_e = sb.pop_front();
            chk("rsp_cycle", cyc, mon_e.cyc);
            chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
            chk("rsp_data", 32'(rsp_data), 32'(mon_e.d));
         end
      end
   end

   task automatic idle_inputs();
      {clr_req, rd0_valid, rd1_valid, wr_valid} = '0;
      {rd0_addr, rd1_addr, wr_addr, wr_data} = '0;
   endtask

   // checks n cycles of fill from entry 0 with random (ignored) requests applied
   task automatic sweep(string nm, int n);
      int bad = 0, first = -1;
      for (int k = 0; k < n; k++) begin
         rd0_valid = 1'($urandom); rd1_valid = 1'($urandom); wr_valid = 1'($urandom);
         clr_req = 1'($urandom); rd0_addr = 11'($urandom); rd1_addr = 11'($urandom);
         wr_addr = 11'($urandom); wr_data = 2'($urandom);
         #1;
         if (!(mem_W0_en === 1'b1 && mem_W0_addr === 11'(k) && mem_W0_data === 2'b00 &&
               mem_R0_en === 1'b0 && {rd0_ready, rd1_ready, wr_ready} === 3'b000 &&
               init_done === 1'b0)) begin
            bad++;
            if (first < 0) first = k;
         end
         @(negedge clock);
      end
      idle_inputs();
      #1;
      chk({nm, "_bad_cycles(first)"}, bad == 0 ? 32'd0 : 32'(first), 32'd0);
      if (n == 2048) begin
         chk({nm, "_init_done"}, 32'(init_done), 32'd1);
         foreach (ref_mem[i]) ref_mem[i] = 2'b00;
      end
   endtask

   // one IDLE cycle; the model decides grants from the round-robin rule
   task automatic step(logic v0, logic [10:0] a0, logic v1, logic [10:0] a1,
                       logic wv, logic [10:0] wa, logic [1:0] wd, logic clr);
      int w;
      logic [10:0] a;
      exp_t e;
      rd0_valid = v0; rd0_addr = a0; rd1_valid = v1; rd1_addr = a1;
      wr_valid = wv; wr_addr = wa; wr_data = wd; clr_req = clr;
      #1;
      w = clr ? -1 : (v0 && v1) ? (last_win == 0 ? 1 : 0) : v0 ? 0 : v1 ? 1 : -1;
      chk("rd0_ready", 32'(rd0_ready), 32'(w == 0));
      chk("rd1_ready", 32'(rd1_ready), 32'(w == 1));
      chk("wr_ready", 32'(wr_ready), 32'(!clr));
      chk("W0_en", 32'(mem_W0_en), 32'(!clr && wv));
      chk("R0_en", 32'(mem_R0_en), 32'(w >= 0));
      if (!clr && wv) chk("W0_addr", 32'(mem_W0_addr), 32'(wa));
      if (w >= 0) begin
         a = w == 1 ? a1 : a0;
         chk("R0_addr", 32'(mem_R0_addr), 32'(a));
         e.cyc = cyc + 1;
         e.id = w[0];
         e.d = (wv && wa == a) ? wd : ref_mem[a];
         sb.push_back(e);
         last_win = w;
      end
      if (!clr && wv) ref_mem[wa] = wd;
      @(negedge clock);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0;
      idle_inputs();
      rd0_valid = 1'b1; rd1_valid = 1'b1; wr_valid = 1'b1;
      repeat (3) @(negedge clock);
      #1;
      chk("rst_init_done", 32'(init_done), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_W0_en", 32'(mem_W0_en), 32'd1);
      chk("rst_W0_addr", 32'(mem_W0_addr), 32'd0);
      chk("rst_readies", 32'({rd0_ready, rd1_ready, wr_ready}), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      last_win = -1;
      sweep("sweep", 2048);
      // arbitration straight after reset: 0,1,0,1
      for (int i = 0; i < 4; i++) step(1, 11'($urandom), 1, 11'($urandom), 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 11'd5, 2'b10, 0);
      step(0, 0, 1, 11'd5, 0, 0, 0, 0);
      step(1, 11'd9, 0, 0, 0, 0, 0, 0);
      step(1, 11'd100, 0, 0, 1, 11'd100, 2'b11, 0);
      for (int i = 0; i < 400; i++)
         step(1'($urandom), 11'($urandom_range(0, 31)), 1'($urandom), 11'($urandom_range(0, 31)),
              1'($urandom), 11'($urandom_range(0, 31)), 2'($urandom), 0);
      step(0, 0, 0, 0, 1, 11'd7, 2'b01, 0);
      step(1, 11'd7, 0, 0, 0, 0, 0, 0);
      step(1, 11'd7, 1, 11'd5, 1, 11'd7, 2'b11, 1);
      chk("clr_init_done_fall", 32'(init_done), 32'd0);
      sweep("clr_sweep", 2048);
      step(1, 11'd7, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 11'd100, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      sweep("part_sweep", 1000);
      chk("mid_cnt", 32'(mem_W0_addr), 32'd1000);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_W0_addr", 32'(mem_W0_addr), 32'd0);
      chk("mid_rst_init_done", 32'(init_done), 32'd0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      last_win = -1;
      sweep("resweep", 2048);
      step(1, 11'd3, 1, 11'd4, 0, 0, 0, 0);
      step(1, 11'd3, 1, 11'd4, 0, 0, 0, 0);
      for (int i = 0; i < 100; i++)
         step(1'($urandom), 11'($urandom), 1'($urandom), 11'($urandom),
              1'($urandom), 11'($urandom), 2'($urandom), 0);
      repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("rsp_drain", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
